// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Shared types and constants for the dispense arbiter.
//               Holds the drink codes, response codes, FSM state encoding
//               and the default drink price.
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

    localparam int NUM_DRINKS      = 4;
    localparam int DEF_DRINK_PRICE = 3;

    typedef enum logic [1:0] {
        DRINK_00 = 2'b00,
        DRINK_01 = 2'b01,
        DRINK_10 = 2'b10,
        DRINK_11 = 2'b11
    } drink_e;

    typedef enum logic [1:0] {
        RESP_OK        = 2'b00,
        RESP_NO_CREDIT = 2'b01,
        RESP_SOLD_OUT  = 2'b10,
        RESP_FAULT     = 2'b11
    } resp_code_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CHECK    = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_RESPOND  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/vend_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vend_rr_arbiter
// Description : Round-robin arbiter over NUM_PANELS requesters (2..4).
//               The grant is combinational from req and the pointer; the
//               pointer moves past the granted index when advance is high.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               req             - request vector
//               advance         - grant is being taken this cycle
//               grant           - one-hot grant
//               grant_idx       - binary index of the grant
// Revision    : 1.0 - initial release
// ============================================================================
module vend_rr_arbiter #(
    parameter int NUM_PANELS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_PANELS-1:0] req,
    input  logic                  advance,
    output logic [NUM_PANELS-1:0] grant,
    output logic [1:0]            grant_idx
);

    logic [1:0] r_ptr;
    logic       w_found;

    // Two passes: first the requesters at or above the pointer, then the
    // ones below it, which gives the wrap-around search without modulo math.
    always_comb begin
        grant     = '0;
        grant_idx = 2'd0;
        w_found   = 1'b0;
        for (int i = 0; i < NUM_PANELS; i++) begin
            if (!w_found && req[i] && (i >= int'(r_ptr))) begin
                w_found   = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = 2'(i);
            end
        end
        for (int i = 0; i < NUM_PANELS; i++) begin
            if (!w_found && req[i] && (i < int'(r_ptr))) begin
                w_found   = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 2'd0;
        end else if (advance) begin
            r_ptr <= (int'(grant_idx) == NUM_PANELS - 1) ? 2'd0 : grant_idx + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vend_dispense_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vend_dispense_arbiter
// Description : Shares one dispense motor between NUM_PANELS vending panels.
//               Picks a request round-robin, checks stock and credit, runs
//               the motor with a timeout and returns one response (code and
//               change) per accepted request. Keeps per-drink stock counters
//               with saturating restock.
// Ports       : clk, reset                 - clock, sync active-high reset
//               req_valid/drink/credit     - per-panel request
//               req_ready                  - one-hot accept pulse
//               motor_en/drink, motor_done - motor interface
//               restock_valid/drink        - add one unit of a drink
//               resp_valid/panel/code/change - response pulse
//               sold_out                   - per-drink empty flags
// Revision    : 1.0 - initial release
// ============================================================================
module vend_dispense_arbiter
    import vend_pkg::*;
#(
    parameter int NUM_PANELS    = 2,
    parameter int CREDIT_W      = 4,
    parameter int DRINK_PRICE   = DEF_DRINK_PRICE,
    parameter int STOCK_W       = 3,
    parameter int STOCK_INIT    = 4,
    parameter int MOTOR_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PANELS-1:0]          req_valid,
    input  logic [2*NUM_PANELS-1:0]        req_drink,
    input  logic [CREDIT_W*NUM_PANELS-1:0] req_credit,
    output logic [NUM_PANELS-1:0]          req_ready,
    output logic                           motor_en,
    output logic [1:0]                     motor_drink,
    input  logic                           motor_done,
    input  logic                           restock_valid,
    input  logic [1:0]                     restock_drink,
    output logic                           resp_valid,
    output logic [1:0]                     resp_panel,
    output logic [1:0]                     resp_code,
    output logic [CREDIT_W-1:0]            resp_change,
    output logic [NUM_DRINKS-1:0]          sold_out
);

    localparam int                    c_tmo_w    = $clog2(MOTOR_TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0]    c_tmo_last = c_tmo_w'(MOTOR_TIMEOUT - 1);
    localparam logic [CREDIT_W-1:0]   c_price    = CREDIT_W'(DRINK_PRICE);

    state_e                r_state;
    state_e                w_next;

    logic [NUM_PANELS-1:0] w_gnt;
    logic [1:0]            w_gnt_idx;
    logic                  w_grant_en;
    logic [1:0]            w_sel_drink;
    logic [CREDIT_W-1:0]   w_sel_credit;

    logic [1:0]            r_panel;
    logic [1:0]            r_drink;
    logic [CREDIT_W-1:0]   r_credit;
    logic [c_tmo_w-1:0]    r_tmo;

    logic [STOCK_W-1:0]    w_stock [NUM_DRINKS];

    logic                  w_dec_en;
    logic                  w_to_resp;
    resp_code_e            w_code;
    logic [CREDIT_W-1:0]   w_change;

    logic [1:0]            r_resp_panel;
    resp_code_e            r_resp_code;
    logic [CREDIT_W-1:0]   r_resp_change;

    vend_rr_arbiter #(
        .NUM_PANELS (NUM_PANELS)
    ) u_rr (
        .clk       (clk),
        .rst       (reset),
        .req       (req_valid),
        .advance   (w_grant_en),
        .grant     (w_gnt),
        .grant_idx (w_gnt_idx)
    );

    // Request fields of the granted panel.
    always_comb begin
        w_sel_drink  = 2'd0;
        w_sel_credit = '0;
        for (int i = 0; i < NUM_PANELS; i++) begin
            if (w_gnt[i]) begin
                w_sel_drink  = req_drink[2*i +: 2];
                w_sel_credit = req_credit[CREDIT_W*i +: CREDIT_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_grant_en = 1'b0;
        w_to_resp  = 1'b0;
        w_dec_en   = 1'b0;
        w_code     = RESP_OK;
        w_change   = r_credit;
        case (r_state)
            ST_IDLE: begin
                // Gated by reset so a panel never sees an accept that the
                // reset is about to discard.
                if (!reset && (|w_gnt)) begin
                    w_grant_en = 1'b1;
                    w_next     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_stock[r_drink] == '0) begin
                    w_code    = RESP_SOLD_OUT;
                    w_to_resp = 1'b1;
                    w_next    = ST_RESPOND;
                end else if (r_credit < c_price) begin
                    w_code    = RESP_NO_CREDIT;
                    w_to_resp = 1'b1;
                    w_next    = ST_RESPOND;
                end else begin
                    w_next    = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                // A done arriving on the final timeout cycle still counts.
                if (motor_done) begin
                    w_dec_en  = 1'b1;
                    w_code    = RESP_OK;
                    w_change  = r_credit - c_price;
                    w_to_resp = 1'b1;
                    w_next    = ST_RESPOND;
                end else if (r_tmo == c_tmo_last) begin
                    w_code    = RESP_FAULT;
                    w_to_resp = 1'b1;
                    w_next    = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_panel       <= 2'd0;
            r_drink       <= 2'd0;
            r_credit      <= '0;
            r_resp_panel  <= 2'd0;
            r_resp_code   <= RESP_OK;
            r_resp_change <= '0;
        end else begin
            if (w_grant_en) begin
                r_panel  <= w_gnt_idx;
                r_drink  <= w_sel_drink;
                r_credit <= w_sel_credit;
            end
            if (w_to_resp) begin
                r_resp_panel  <= r_panel;
                r_resp_code   <= w_code;
                r_resp_change <= w_change;
            end
        end
    end

    // Counts cycles spent in DISPENSE; cleared whenever the motor is idle.
    always_ff @(posedge clk) begin
        if (reset || (r_state != ST_DISPENSE)) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-drink stock counters
    // ------------------------------------------------------------------
    for (genvar d = 0; d < NUM_DRINKS; d++) begin : g_stock
        logic [STOCK_W-1:0] r_cnt;
        logic               w_inc;
        logic               w_dec;

        assign w_inc = restock_valid && (restock_drink == 2'(d));
        assign w_dec = w_dec_en && (r_drink == 2'(d));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= STOCK_W'(STOCK_INIT);
            end else if (w_inc && w_dec) begin
                r_cnt <= r_cnt;
            end else if (w_inc && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_dec) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end

        assign w_stock[d]  = r_cnt;
        assign sold_out[d] = (r_cnt == '0);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready   = w_grant_en ? w_gnt : '0;
    assign motor_en    = (r_state == ST_DISPENSE);
    assign motor_drink = r_drink;
    assign resp_valid  = (r_state == ST_RESPOND);
    assign resp_panel  = r_resp_panel;
    assign resp_code   = r_resp_code;
    assign resp_change = r_resp_change;

endmodule
`default_nettype wire
